// File: rtl/mem_stage_if.sv
// Data-bus bundle between the memory stage (master) and the memory/cache side (slave).
interface mem_stage_if #(
    parameter int W = 32
);
    logic           dbus_req;
    logic           dbus_we;
    logic [W-1:0]   dbus_addr;
    logic [W-1:0]   dbus_wdata;
    logic [W/8-1:0] dbus_be;
    logic           dbus_ack;
    logic           dbus_err;
    logic [W-1:0]   dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        input  dbus_ack, dbus_err, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        output dbus_ack, dbus_err, dbus_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack bus, stalls upstream while
// busy, aligns/extends load data and registers writeback and exception results.
module mem_stage #(
    parameter int WordSize = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                valid_in,
    input  logic [4:0]          rdn_in,
    input  logic [WordSize-1:0] alu_out,
    input  logic [WordSize-1:0] mem_data,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          funct3,
    output logic                stall,
    mem_stage_if.master         bus,
    output logic                wb_valid,
    output logic [4:0]          rdn_wb,
    output logic [WordSize-1:0] wb_data,
    output logic                exc_valid,
    output logic [1:0]          exc_code
);
    localparam int NB = WordSize / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2:0]     f3_q, f3_n;
    logic [4:0]     rd_q, rd_n;
    logic           req_n, we_n;
    logic [WordSize-1:0] addr_n, wdata_n;
    logic [NB-1:0]  be_n;
    logic           wbv_n, excv_n;
    logic [4:0]     rdwb_n;
    logic [WordSize-1:0] wbd_n;
    logic [1:0]     excc_n;

    // Decode of the instruction currently offered by EX/MEM
    logic           is_mem, is_load, illegal, misal, last;
    logic [1:0]     sz;
    logic [NB-1:0]  be_new;
    logic [WordSize-1:0] wd_new, lane, ld_data;

    assign is_mem  = mem_read | mem_write;
    assign is_load = mem_read;
    assign sz      = funct3[1:0];
    assign illegal = is_load ? ((funct3[1:0] == 2'b11) || (funct3 == 3'b110))
                             : (funct3[2] || (funct3[1:0] == 2'b11));
    assign misal   = ((sz == 2'b01) && alu_out[0]) ||
                     ((sz == 2'b10) && (alu_out[1:0] != 2'b00));
    assign last    = (cnt == CNT_LAST);

    // Per byte lane: enable and lane-replicated store data
    for (genvar g = 0; g < NB; g++) begin : g_lane
        assign be_new[g] = (sz == 2'b00) ? (alu_out[1:0] == 2'(g)) :
                           (sz == 2'b01) ? (alu_out[1] == 1'(g / 2)) : 1'b1;
        assign wd_new[g*8 +: 8] = (sz == 2'b00) ? mem_data[7:0] :
                                  (sz == 2'b01) ? mem_data[(g % 2)*8 +: 8] :
                                                  mem_data[g*8 +: 8];
    end

    // Shift the addressed lane down to bit 0, then extend by access type
    assign lane = bus.dbus_rdata >> {bus.dbus_addr[1:0], 3'b000};

    always_comb begin
        ld_data = lane;
        case (f3_q)
            3'b000:  ld_data = {{(WordSize-8){lane[7]}}, lane[7:0]};
            3'b001:  ld_data = {{(WordSize-16){lane[15]}}, lane[15:0]};
            3'b100:  ld_data = {{(WordSize-8){1'b0}}, lane[7:0]};
            3'b101:  ld_data = {{(WordSize-16){1'b0}}, lane[15:0]};
            default: ld_data = lane;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        f3_n    = f3_q;
        rd_n    = rd_q;
        req_n   = bus.dbus_req;
        we_n    = bus.dbus_we;
        addr_n  = bus.dbus_addr;
        wdata_n = bus.dbus_wdata;
        be_n    = bus.dbus_be;
        wbv_n   = 1'b0;
        rdwb_n  = rdn_wb;
        wbd_n   = wb_data;
        excv_n  = 1'b0;
        excc_n  = exc_code;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    if (!is_mem) begin
                        wbv_n  = 1'b1;
                        rdwb_n = rdn_in;
                        wbd_n  = alu_out;
                    end else if (illegal) begin
                        excv_n = 1'b1;
                        excc_n = 2'b00;
                    end else if (misal) begin
                        excv_n = 1'b1;
                        excc_n = 2'b01;
                    end else begin
                        stall   = 1'b1;
                        state_n = BUSY;
                        cnt_n   = '0;
                        req_n   = 1'b1;
                        we_n    = !is_load;
                        addr_n  = alu_out;
                        wdata_n = wd_new;
                        be_n    = be_new;
                        f3_n    = funct3;
                        rd_n    = rdn_in;
                    end
                end
            end
            BUSY: begin
                // The final timeout cycle releases upstream even without an ack
                stall = !bus.dbus_ack && !last;
                if (bus.dbus_ack) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                    if (bus.dbus_err) begin
                        excv_n = 1'b1;
                        excc_n = 2'b10;
                    end else if (!bus.dbus_we) begin
                        wbv_n  = 1'b1;
                        rdwb_n = rd_q;
                        wbd_n  = ld_data;
                    end
                end else if (last) begin
                    excv_n  = 1'b1;
                    excc_n  = 2'b11;
                    req_n   = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            cnt            <= '0;
            f3_q           <= '0;
            rd_q           <= '0;
            bus.dbus_req   <= 1'b0;
            bus.dbus_we    <= 1'b0;
            bus.dbus_addr  <= '0;
            bus.dbus_wdata <= '0;
            bus.dbus_be    <= '0;
            wb_valid       <= 1'b0;
            rdn_wb         <= '0;
            wb_data        <= '0;
            exc_valid      <= 1'b0;
            exc_code       <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            f3_q           <= f3_n;
            rd_q           <= rd_n;
            bus.dbus_req   <= req_n;
            bus.dbus_we    <= we_n;
            bus.dbus_addr  <= addr_n;
            bus.dbus_wdata <= wdata_n;
            bus.dbus_be    <= be_n;
            wb_valid       <= wbv_n;
            rdn_wb         <= rdwb_n;
            wb_data        <= wbd_n;
            exc_valid      <= excv_n;
            exc_code       <= excc_n;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: randomized instruction stream against a transaction-level model.
module tb_mem_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_in;
    logic [4:0]  rdn_in;
    logic [31:0] alu_out, mem_data;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic        stall;
    logic        wb_valid, exc_valid;
    logic [4:0]  rdn_wb;
    logic [31:0] wb_data;
    logic [1:0]  exc_code;

    mem_stage_if #(.W(32)) bus ();

    mem_stage #(.WordSize(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in), .rdn_in(rdn_in),
        .alu_out(alu_out), .mem_data(mem_data), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .stall(stall), .bus(bus),
        .wb_valid(wb_valid), .rdn_wb(rdn_wb), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_code(exc_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;   // 1 writeback, 2 exception
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  code;
    } exp_t;
    exp_t expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outcome of one instruction, straight from the architectural rules
    function automatic void model(input logic rd_e, input logic wr_e, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] rdat, input int dly, input logic e,
                                  output int kind, output logic [1:0] code,
                                  output logic [31:0] wbd, output logic acc,
                                  output logic [3:0] mbe, output logic [31:0] mwd);
        int sz, off;
        logic [31:0] mask, v;
        logic legal;
        kind = 0; code = 0; wbd = 0; acc = 0; mbe = 0; mwd = 0;
        if (!rd_e && !wr_e) begin
            kind = 1; wbd = a;
            return;
        end
        if (rd_e) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else      legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
        if (!legal) begin kind = 2; code = 2'b00; return; end
        sz  = 1 << f3[1:0];
        off = int'(a[1:0]);
        if ((off % sz) != 0) begin kind = 2; code = 2'b01; return; end
        acc  = 1;
        mbe  = 4'(((1 << sz) - 1) << off);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 1);
        if (sz == 1)      mwd = {24'h0, d[7:0]} * 32'h0101_0101;
        else if (sz == 2) mwd = {16'h0, d[15:0]} * 32'h0001_0001;
        else              mwd = d;
        v = (rdat >> (8 * off)) & mask;
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        if (dly >= TO)  begin kind = 2; code = 2'b11; end
        else if (e)     begin kind = 2; code = 2'b10; end
        else if (rd_e)  begin kind = 1; wbd = v; end
    endfunction

    // Every cycle: either the scheduled result is visible, or nothing is
    always @(negedge clk) begin
        if (rstn) begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL result_missing due_cycle=%0d now=%0d", expq[0].cyc, cyc);
                void'(expq.pop_front());
            end
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                if (expq[0].kind == 1) begin
                    chk("wb_valid", wb_valid, 1);
                    chk("wb_exc_excl", exc_valid, 0);
                    chk("rdn_wb", rdn_wb, expq[0].rd);
                    chk("wb_data", wb_data, expq[0].data);
                end else begin
                    chk("exc_valid", exc_valid, 1);
                    chk("exc_wb_excl", wb_valid, 0);
                    chk("exc_code", exc_code, expq[0].code);
                end
                void'(expq.pop_front());
            end else begin
                chk("wb_valid_idle", wb_valid, 0);
                chk("exc_valid_idle", exc_valid, 0);
            end
        end
    end

    // Present one instruction and act as the bus slave; cycle count comes from the model
    task automatic do_op(input logic rd_e, input logic wr_e, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rdat, input int dly, input logic e,
                         output int nstall, output logic [3:0] be_s, output logic [31:0] wd_s);
        int kind, nb, k;
        logic [1:0] code;
        logic [31:0] wbd, mwd;
        logic acc, exp_st;
        logic [3:0] mbe;
        exp_t x;
        model(rd_e, wr_e, f3, a, d, rdat, dly, e, kind, code, wbd, acc, mbe, mwd);
        nb = !acc ? 0 : ((dly < TO) ? dly + 1 : TO);
        valid_in = 1; rdn_in = rd; alu_out = a; mem_data = d;
        mem_read = rd_e; mem_write = wr_e; funct3 = f3;
        if (kind != 0) begin
            x.cyc = cyc + 1 + nb; x.kind = kind; x.rd = rd; x.data = wbd; x.code = code;
            expq.push_back(x);
        end
        nstall = 0; be_s = 0; wd_s = 0; k = 0;
        for (int c = 0; c <= nb; c++) begin
            if (c == 0) begin
                bus.dbus_ack = 0; bus.dbus_err = 0; bus.dbus_rdata = $urandom;
                chk("req_before", bus.dbus_req, 0);
            end else begin
                k = c - 1;
                chk("req_busy", bus.dbus_req, 1);
                chk("dbus_addr", bus.dbus_addr, a);
                chk("dbus_we", bus.dbus_we, wr_e & !rd_e);
                chk("dbus_be", bus.dbus_be, mbe);
                chk("dbus_wdata", bus.dbus_wdata, mwd);
                be_s = bus.dbus_be; wd_s = bus.dbus_wdata;
                bus.dbus_ack   = (k == dly);
                bus.dbus_err   = (k == dly) & e;
                bus.dbus_rdata = (k == dly) ? rdat : $urandom;
            end
            @(negedge clk);
            exp_st = (c == 0) ? acc : ((k != dly) && (k != TO - 1));
            chk("stall", stall, exp_st);
            nstall += int'(stall);
            @(posedge clk); #1;
        end
        bus.dbus_ack = 0; bus.dbus_err = 0;
    endtask

    task automatic gap();
        valid_in = 0; rdn_in = 5'($urandom); alu_out = $urandom;
        mem_read = 1'($urandom); mem_write = 1'($urandom); funct3 = 3'($urandom);
        @(negedge clk);
        chk("stall_gap", stall, 0);
        chk("req_gap", bus.dbus_req, 0);
        @(posedge clk); #1;
    endtask

    int          ns, kind;
    logic [3:0]  bes, mbe;
    logic [31:0] wds, wbd, mwd;
    logic [1:0]  code;
    logic        acc;

    initial begin
        rstn = 0; valid_in = 0; rdn_in = 0; alu_out = 0; mem_data = 0;
        mem_read = 0; mem_write = 0; funct3 = 0;
        bus.dbus_ack = 0; bus.dbus_err = 0; bus.dbus_rdata = 0;
        #2;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_exc_valid", exc_valid, 0);
        chk("rst_req", bus.dbus_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_rdn_wb", rdn_wb, 0);
        chk("rst_exc_code", exc_code, 0);
        chk("rst_be", bus.dbus_be, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1;

        // Model pinned to hand-computed values
        model(1, 0, 3'b000, 32'h103, 0, 32'h8012_3456, 0, 0, kind, code, wbd, acc, mbe, mwd);
        chk("model_lb", wbd, 32'hFFFF_FF80);
        model(1, 0, 3'b100, 32'h103, 0, 32'h8012_3456, 0, 0, kind, code, wbd, acc, mbe, mwd);
        chk("model_lbu", wbd, 32'h0000_0080);
        model(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 0, 0, kind, code, wbd, acc, mbe, mwd);
        chk("model_sh_be", mbe, 4'b1100);
        chk("model_sh_wd", mwd, 32'hABCD_ABCD);
        model(1, 0, 3'b010, 32'h101, 0, 0, 0, 0, kind, code, wbd, acc, mbe, mwd);
        chk("model_misal", code, 2'b01);
        model(1, 0, 3'b011, 32'h100, 0, 0, 0, 0, kind, code, wbd, acc, mbe, mwd);
        chk("model_illegal", code, 2'b00);

        // Directed cases
        do_op(1, 0, 3'b010, 5'd7, 32'h100, 0, 32'hDEAD_BEEF, 3, 0, ns, bes, wds);
        chk("lw_stall_cycles", ns, 4);
        do_op(1, 0, 3'b000, 5'd8, 32'h103, 0, 32'h8012_3456, 0, 0, ns, bes, wds);
        chk("lb_min_stall", ns, 1);
        do_op(1, 0, 3'b100, 5'd9, 32'h103, 0, 32'h8012_3456, 1, 0, ns, bes, wds);
        do_op(0, 1, 3'b001, 5'd10, 32'h202, 32'h1234_ABCD, 0, 0, 0, ns, bes, wds);
        chk("sh_be", bes, 4'b1100);
        chk("sh_wdata", wds, 32'hABCD_ABCD);
        do_op(1, 0, 3'b010, 5'd11, 32'h101, 0, 0, 0, 0, ns, bes, wds);
        chk("misal_stall", ns, 0);
        do_op(1, 0, 3'b011, 5'd12, 32'h100, 0, 0, 0, 0, ns, bes, wds);
        do_op(1, 0, 3'b010, 5'd13, 32'h300, 0, 0, 99, 0, ns, bes, wds);
        chk("timeout_stall", ns, TO);
        do_op(0, 1, 3'b010, 5'd14, 32'h304, 32'h5555_AAAA, 0, 1, 1, ns, bes, wds);
        do_op(1, 1, 3'b101, 5'd15, 32'h306, 0, 32'h9ABC_1234, 0, 0, ns, bes, wds);

        // Randomized stream
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = (a[0] & 1'($urandom)) ? a[1:0] : {a[1], 1'b0};
            do_op(1'($urandom), 1'($urandom), 3'($urandom_range(7)), 5'($urandom), a,
                  $urandom, $urandom, $urandom_range(5), ($urandom_range(5) == 0), ns, bes, wds);
            if ($urandom_range(2) == 0) gap();
        end

        // Reset in the middle of an access aborts it silently
        valid_in = 1; rdn_in = 5'd20; alu_out = 32'h40; mem_data = 0;
        mem_read = 1; mem_write = 0; funct3 = 3'b010;
        @(posedge clk); #1;
        chk("req_before_rst", bus.dbus_req, 1);
        rstn = 0; valid_in = 0;
        #1;
        chk("req_drop_rst", bus.dbus_req, 0);
        chk("wb_valid_rst", wb_valid, 0);
        chk("exc_valid_rst", exc_valid, 0);
        chk("stall_rst", stall, 0);
        @(posedge clk); #1;
        rstn = 1;
        do_op(0, 0, 3'b000, 5'd3, 32'h5, 0, 0, 0, 0, ns, bes, wds);
        gap();
        gap();
        chk("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
